// File: rtl/rf_write_arbiter_if.sv
// Handshake and write-port bundle between the two writeback requesters,
// the arbiter and the register file.
interface rf_write_arbiter_if #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 5
);
  // freeze request from the pipeline control
  logic              hold;

  // requester A: in-order pipeline writeback
  logic              a_valid;
  logic [ADDR_W-1:0] a_rd;
  logic [DATA_W-1:0] a_data;
  logic              a_ready;

  // requester B: multi-cycle / memory writeback
  logic              b_valid;
  logic [ADDR_W-1:0] b_rd;
  logic [DATA_W-1:0] b_data;
  logic              b_ready;

  // registered register-file write port
  logic              rf_we;
  logic [ADDR_W-1:0] rf_rd;
  logic [DATA_W-1:0] rf_wdata;

  // high while B holds forced priority
  logic              forced;

  // requester / register-file side
  modport master (
    output hold,
    output a_valid, a_rd, a_data,
    input  a_ready,
    output b_valid, b_rd, b_data,
    input  b_ready,
    input  rf_we, rf_rd, rf_wdata,
    input  forced
  );

  // arbiter side
  modport slave (
    input  hold,
    input  a_valid, a_rd, a_data,
    output a_ready,
    input  b_valid, b_rd, b_data,
    output b_ready,
    output rf_we, rf_rd, rf_wdata,
    output forced
  );
endinterface

// File: rtl/rf_write_arbiter.sv
// Register-file write-port arbiter: fixed priority to the pipeline (A),
// with a starvation counter that hands the port to the memory unit (B)
// after it has waited STARVE_LIMIT consecutive cycles.
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   A_PRI | normal: A wins when both are valid; B's wait is counted
//   B_PRI | B starved: B wins next unfrozen cycle (or A if B withdrew)
module rf_write_arbiter #(
  parameter int DATA_W       = 64,
  parameter int ADDR_W       = 5,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                clk,
  input  logic                reset,
  rf_write_arbiter_if.slave   bus
);

  // Out-of-range limits are clamped to the 4-bit counter's usable range.
  localparam int LIMIT_C = (STARVE_LIMIT < 1)  ? 1  :
                           (STARVE_LIMIT > 15) ? 15 : STARVE_LIMIT;
  localparam logic [3:0] LIMIT = 4'(LIMIT_C);

  typedef enum logic {
    A_PRI = 1'b0,
    B_PRI = 1'b1
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [3:0]        starve_cnt;
  logic [3:0]        starve_nxt;
  logic              a_gnt;
  logic              b_gnt;

  logic              rf_we_q;
  logic [ADDR_W-1:0] rf_rd_q;
  logic [DATA_W-1:0] rf_wdata_q;

  // Grant selection, starvation count and next state.  Grants are blocked
  // during reset so that nothing is accepted that the register would drop.
  always_comb begin
    a_gnt      = 1'b0;
    b_gnt      = 1'b0;
    state_nxt  = state;
    starve_nxt = starve_cnt;

    if (reset && !bus.hold) begin
      if (state == B_PRI) begin
        b_gnt = bus.b_valid;
        a_gnt = bus.a_valid && !bus.b_valid;
      end else begin
        a_gnt = bus.a_valid;
        b_gnt = bus.b_valid && !bus.a_valid;
      end

      if (!bus.b_valid || b_gnt) begin
        starve_nxt = 4'd0;
      end else if (starve_cnt < LIMIT) begin
        starve_nxt = starve_cnt + 4'd1;
      end

      case (state)
        A_PRI: begin
          // B_PRI is entered on the same cycle the count reaches the limit
          if (bus.b_valid && !b_gnt && (starve_nxt == LIMIT)) begin
            state_nxt = B_PRI;
          end
        end
        B_PRI: begin
          // leave once B is served, or if B withdrew its request
          if (b_gnt || !bus.b_valid) begin
            state_nxt = A_PRI;
          end
        end
        default: state_nxt = A_PRI;
      endcase
    end
  end

  // FSM state and starvation counter; hold freezes both via the defaults.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= A_PRI;
      starve_cnt <= 4'd0;
    end else begin
      state      <= state_nxt;
      starve_cnt <= starve_nxt;
    end
  end

  // Write-port register: one-cycle pulse per grant, x0 writes suppressed,
  // address/data held when nothing is granted.
  always_ff @(posedge clk) begin
    if (!reset) begin
      rf_we_q    <= 1'b0;
      rf_rd_q    <= '0;
      rf_wdata_q <= '0;
    end else begin
      rf_we_q <= (a_gnt && (bus.a_rd != '0)) || (b_gnt && (bus.b_rd != '0));
      if (a_gnt) begin
        rf_rd_q    <= bus.a_rd;
        rf_wdata_q <= bus.a_data;
      end else if (b_gnt) begin
        rf_rd_q    <= bus.b_rd;
        rf_wdata_q <= bus.b_data;
      end
    end
  end

  assign bus.a_ready  = a_gnt;
  assign bus.b_ready  = b_gnt;
  assign bus.rf_we    = rf_we_q;
  assign bus.rf_rd    = rf_rd_q;
  assign bus.rf_wdata = rf_wdata_q;
  assign bus.forced   = (state == B_PRI);

endmodule
